// File: rtl/mem_access_unit_pkg.sv
// Shared constants and helpers for the data-memory access unit.
// Access-size encodings, pending-entry field widths, alignment check.
package mem_access_unit_pkg;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   localparam int SIZE_W = 2;
   localparam int OFF_W  = 2;

   function automatic logic misaligned(
      input logic [SIZE_W-1:0] size,
      input logic [OFF_W-1:0]  off
   );
      return (size == MEM_SIZE_H && off[0]) ||
             (size == MEM_SIZE_W && off != 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus: req/addr_ok request channel, data_ok/rdata return.
// master = access unit (drives request), slave = memory side.
interface mem_access_unit_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size,
      output data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size,
      input  data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_pend_fifo.sv
// In-order pending queue: push/pop, occupancy count, broadcast kill-all.
// Ports: push_i/din_i, pop_i, kill_all_i -> dout_o, killed_o, count_o, empty_o.
module mem_pend_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [W-1:0]               din_i,
   input  logic                       pop_i,
   input  logic                       kill_all_i,
   output logic [W-1:0]               dout_o,
   output logic                       killed_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [DEPTH-1:0] killed_q, killed_d;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   function automatic logic [PW-1:0] inc(
      input logic [PW-1:0] p
   );
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_d     = push_i ? inc(wr_q) : wr_q;
      rd_d     = pop_i ? inc(rd_q) : rd_q;
      cnt_d    = cnt_q;
      if (push_i && !pop_i)
         cnt_d = cnt_q + 1'b1;
      else if (pop_i && !push_i)
         cnt_d = cnt_q - 1'b1;
      killed_d = kill_all_i ? '1 : killed_q;
      // a fresh entry is always live
      if (push_i)
         killed_d[wr_q] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         killed_q <= '0;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         killed_q <= killed_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i)
         mem_q[wr_q] <= din_i;
   end

   assign dout_o   = mem_q[rd_q];
   assign killed_o = killed_q[rd_q];
   assign count_o  = cnt_q;
   assign empty_o  = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues ops onto the data bus, tracks MAX_OUT in flight.
// Ports: op_* in, dbus (master), rsp_* registered out, busy/stall/proto_err.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MAX_OUT = 2,
   parameter int TAG_W   = 5
) (
   input  logic                cpu_clk_50M,
   input  logic                cpu_rst_n,
   input  logic                op_valid,
   input  logic                op_load,
   input  logic [1:0]          op_size,
   input  logic                op_unsigned,
   input  logic [31:0]         op_addr,
   input  logic [31:0]         op_wdata,
   input  logic [TAG_W-1:0]    op_tag,
   output logic                op_ready,
   output logic                op_misalign,
   input  logic                flush,
   mem_access_unit_if.master   dbus,
   output logic                rsp_valid,
   output logic                rsp_load,
   output logic [TAG_W-1:0]    rsp_tag,
   output logic [31:0]         rsp_data,
   output logic                busy,
   output logic                stall,
   output logic                proto_err
);

   localparam int CW = $clog2(MAX_OUT + 1);

   typedef struct packed {
      logic              load;
      logic [SIZE_W-1:0] size;
      logic              uns;
      logic [OFF_W-1:0]  off;
      logic [TAG_W-1:0]  tag;
   } ent_t;

   function automatic logic [3:0] strb_f(
      input logic [1:0] sz,
      input logic [1:0] off
   );
      logic [3:0] s;
      unique case (sz)
         MEM_SIZE_B: s = 4'b1000 >> off;
         MEM_SIZE_H: s = off[1] ? 4'b0011 : 4'b1100;
         default:    s = 4'b1111;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] wdata_f(
      input logic [1:0]  sz,
      input logic [31:0] wd
   );
      logic [31:0] r;
      unique case (sz)
         MEM_SIZE_B: r = {4{wd[7:0]}};
         MEM_SIZE_H: r = {2{wd[15:0]}};
         default:    r = wd;
      endcase
      return r;
   endfunction

   // offset 0 is the most significant lane
   function automatic logic [31:0] load_f(
      input logic [31:0] rd,
      input logic [1:0]  sz,
      input logic        uns,
      input logic [1:0]  off
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(rd >> {~off, 3'b000});
      h = off[1] ? rd[15:0] : rd[31:16];
      unique case (sz)
         MEM_SIZE_B: r = {{24{b[7] & ~uns}}, b};
         MEM_SIZE_H: r = {{16{h[15] & ~uns}}, h};
         default:    r = rd;
      endcase
      return r;
   endfunction

   ent_t             push_ent, head;
   logic             head_killed, q_empty;
   logic [CW-1:0]    count;
   logic             mis, req, accept, pop;

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_load_q, rsp_load_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic             perr_q, perr_d;

   assign mis    = op_valid & misaligned(op_size, op_addr[1:0]);
   assign req    = op_valid & ~mis & ~flush &
                   (count < CW'(MAX_OUT));
   assign accept = req & dbus.data_addr_ok;
   assign pop    = dbus.data_data_ok & ~q_empty;

   assign push_ent = '{load: op_load, size: op_size,
                       uns: op_unsigned, off: op_addr[1:0],
                       tag: op_tag};

   mem_pend_fifo #(
      .DEPTH (MAX_OUT),
      .W     ($bits(ent_t))
   ) u_pend (
      .clk_i      (cpu_clk_50M),
      .rst_ni     (cpu_rst_n),
      .push_i     (accept),
      .din_i      (push_ent),
      .pop_i      (pop),
      .kill_all_i (flush),
      .dout_o     (head),
      .killed_o   (head_killed),
      .count_o    (count),
      .empty_o    (q_empty)
   );

   assign dbus.data_req   = req;
   assign dbus.data_wr    = ~op_load;
   assign dbus.data_size  = op_size;
   assign dbus.data_addr  = op_addr;
   assign dbus.data_wstrb = op_load ? 4'b0000
                                    : strb_f(op_size, op_addr[1:0]);
   assign dbus.data_wdata = wdata_f(op_size, op_wdata);

   assign op_misalign = mis;
   assign op_ready    = mis | accept;
   assign stall       = op_valid & ~op_ready;
   assign busy        = ~q_empty;

   always_comb begin
      rsp_load_d  = rsp_load_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_data_d  = rsp_data_q;
      // a flush in the pop cycle also kills the popped entry
      rsp_valid_d = pop & ~head_killed & ~flush;
      perr_d      = perr_q | (dbus.data_data_ok & q_empty);
      if (rsp_valid_d) begin
         rsp_load_d = head.load;
         rsp_tag_d  = head.tag;
         rsp_data_d = head.load
                    ? load_f(dbus.data_rdata, head.size,
                             head.uns, head.off)
                    : 32'h0;
      end
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_load_q  <= 1'b0;
         rsp_tag_q   <= '0;
         rsp_data_q  <= '0;
         perr_q      <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_load_q  <= rsp_load_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_data_q  <= rsp_data_d;
         perr_q      <= perr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_load  = rsp_load_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_data  = rsp_data_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops, queued expected responses.
// A monitor pops and compares every rsp_valid pulse in order.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int TW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          op_valid = 0, op_load = 0, op_unsigned = 0;
   logic [1:0]    op_size = 0;
   logic [31:0]   op_addr = 0, op_wdata = 0;
   logic [TW-1:0] op_tag = 0;
   logic          flush = 0;
   logic          op_ready, op_misalign;
   logic          rsp_valid, rsp_load;
   logic [TW-1:0] rsp_tag;
   logic [31:0]   rsp_data;
   logic          busy, stall, proto_err;

   mem_access_unit_if bus ();

   mem_access_unit #(
      .MAX_OUT (2),
      .TAG_W   (TW)
   ) dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n),
      .op_valid    (op_valid),
      .op_load     (op_load),
      .op_size     (op_size),
      .op_unsigned (op_unsigned),
      .op_addr     (op_addr),
      .op_wdata    (op_wdata),
      .op_tag      (op_tag),
      .op_ready    (op_ready),
      .op_misalign (op_misalign),
      .flush       (flush),
      .dbus        (bus.master),
      .rsp_valid   (rsp_valid),
      .rsp_load    (rsp_load),
      .rsp_tag     (rsp_tag),
      .rsp_data    (rsp_data),
      .busy        (busy),
      .stall       (stall),
      .proto_err   (proto_err)
   );

   typedef struct {
      logic          ld;
      logic [TW-1:0] tag;
      logic [31:0]   data;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && rsp_valid) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected act tag=%0d data=%h exp none",
                        rsp_tag, rsp_data);
            end else begin
               e = sb_q.pop_front();
               if ({rsp_load, rsp_tag, rsp_data} !==
                   {e.ld, e.tag, e.data}) begin
                  bad++;
                  $display("FAIL rsp act ld=%b tag=%0d data=%h exp ld=%b tag=%0d data=%h",
                           rsp_load, rsp_tag, rsp_data, e.ld, e.tag, e.data);
               end
            end
         end
      end
   end

   task automatic present(input logic ld, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input logic [TW-1:0] tg);
      @(negedge clk);
      op_valid = 1; op_load = ld; op_size = sz; op_unsigned = uns;
      op_addr = a; op_wdata = wd; op_tag = tg;
      #1;
   endtask

   task automatic take(input bit exp_rsp, input logic [31:0] exp_data);
      int n = 0;
      while (!op_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!op_ready) begin
         chk("accept_timeout", 32'(op_ready), 32'd1);
         return;
      end
      if (exp_rsp)
         sb_q.push_back('{op_load, op_tag, exp_data});
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      op_valid = 0;
      #1;
   endtask

   task automatic dok(input logic [31:0] rd);
      @(negedge clk);
      bus.data_data_ok = 1;
      bus.data_rdata = rd;
      @(posedge clk);
      #1;
      bus.data_data_ok = 0;
   endtask

   initial begin
      bus.data_addr_ok = 1;
      bus.data_data_ok = 0;
      bus.data_rdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_load", 32'(rsp_load), 0);
      chk("rst_rsp_tag", 32'(rsp_tag), 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_proto_err", 32'(proto_err), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1;

      present(1, MEM_SIZE_W, 0, 32'h100, 0, 5'd3);
      chk("lw_req", 32'(bus.data_req), 1);
      chk("lw_wr", 32'(bus.data_wr), 0);
      chk("lw_strb", 32'(bus.data_wstrb), 0);
      chk("lw_addr", bus.data_addr, 32'h100);
      chk("lw_size", 32'(bus.data_size), 2);
      take(1, 32'h11223344);
      idle();
      chk("lw_busy", 32'(busy), 1);
      repeat (2) @(negedge clk);
      dok(32'h11223344);

      present(1, MEM_SIZE_B, 0, 32'h101, 0, 5'd4);
      take(1, 32'hFFFFFFF4);
      idle(); dok(32'h12F45678);
      present(1, MEM_SIZE_B, 1, 32'h101, 0, 5'd5);
      take(1, 32'h000000F4);
      idle(); dok(32'h12F45678);
      present(1, MEM_SIZE_H, 0, 32'h102, 0, 5'd6);
      take(1, 32'h00005678);
      idle(); dok(32'h12F45678);
      present(1, MEM_SIZE_H, 0, 32'h100, 0, 5'd7);
      take(1, 32'hFFFF8765);
      idle(); dok(32'h87651234);

      present(0, MEM_SIZE_B, 0, 32'h102, 32'hAB, 5'd8);
      chk("sb_wr", 32'(bus.data_wr), 1);
      chk("sb_strb", 32'(bus.data_wstrb), 32'b0010);
      chk("sb_wdata", bus.data_wdata, 32'hABABABAB);
      take(1, 0);
      present(0, MEM_SIZE_H, 0, 32'h100, 32'h1234, 5'd9);
      chk("sh_strb", 32'(bus.data_wstrb), 32'b1100);
      chk("sh_wdata", bus.data_wdata, 32'h12341234);
      take(1, 0);
      idle(); dok(32'hFFFFFFFF); dok(32'hFFFFFFFF);
      present(0, MEM_SIZE_W, 0, 32'h104, 32'hDEADBEEF, 5'd1);
      chk("sw_strb", 32'(bus.data_wstrb), 32'b1111);
      chk("sw_wdata", bus.data_wdata, 32'hDEADBEEF);
      take(1, 0);
      idle(); dok(32'h0);

      present(1, MEM_SIZE_H, 0, 32'h101, 0, 5'd2);
      chk("lh_mis", 32'(op_misalign), 1);
      chk("lh_mis_ready", 32'(op_ready), 1);
      chk("lh_mis_req", 32'(bus.data_req), 0);
      take(0, 0);
      present(1, MEM_SIZE_W, 0, 32'h102, 0, 5'd2);
      chk("lw_mis", 32'(op_misalign), 1);
      chk("lw_mis_req", 32'(bus.data_req), 0);
      take(0, 0);
      idle();
      chk("mis_busy", 32'(busy), 0);

      present(1, MEM_SIZE_W, 0, 32'h200, 0, 5'd10);
      take(1, 32'hA0A0A0A0);
      present(1, MEM_SIZE_H, 0, 32'h202, 0, 5'd11);
      take(1, 32'hFFFF8001);
      present(1, MEM_SIZE_B, 1, 32'h203, 0, 5'd12);
      chk("full_stall", 32'(stall), 1);
      chk("full_req", 32'(bus.data_req), 0);
      chk("full_ready", 32'(op_ready), 0);
      @(negedge clk);
      bus.data_data_ok = 1;
      bus.data_rdata = 32'hA0A0A0A0;
      #1;
      chk("full_pop_req", 32'(bus.data_req), 0);
      chk("full_pop_stall", 32'(stall), 1);
      @(posedge clk);
      #1;
      bus.data_data_ok = 0;
      chk("drain_ready", 32'(op_ready), 1);
      take(1, 32'h000000C3);
      idle();
      dok(32'h00008001);
      dok(32'h000000C3);

      present(1, MEM_SIZE_W, 0, 32'h300, 0, 5'd13);
      take(0, 0);
      present(1, MEM_SIZE_W, 0, 32'h304, 0, 5'd14);
      flush = 1;
      #1;
      chk("flush_req", 32'(bus.data_req), 0);
      chk("flush_ready", 32'(op_ready), 0);
      @(negedge clk);
      flush = 0;
      #1;
      chk("post_flush_req", 32'(bus.data_req), 1);
      take(0, 0);
      @(negedge clk);
      op_valid = 0;
      flush = 1;
      @(negedge clk);
      flush = 0;
      dok(32'h1); dok(32'h2);
      chk("flush_busy", 32'(busy), 0);

      present(1, MEM_SIZE_W, 0, 32'h308, 0, 5'd15);
      take(0, 0);
      present(1, MEM_SIZE_W, 0, 32'h30C, 0, 5'd16);
      take(0, 0);
      idle();
      @(negedge clk);
      bus.data_data_ok = 1;
      flush = 1;
      @(posedge clk);
      #1;
      bus.data_data_ok = 0;
      flush = 0;
      dok(32'h3);
      chk("flush_pop_busy", 32'(busy), 0);

      present(1, MEM_SIZE_W, 0, 32'h400, 0, 5'd17);
      take(1, 32'h00000055);
      idle(); dok(32'h00000055);

      chk("perr_before", 32'(proto_err), 0);
      dok(32'h0);
      chk("perr_after", 32'(proto_err), 1);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised data-memory access unit replacing the single-request memory-stage handshake logic. It sits between the EX/MEM pipeline register and the SRAM-like data bus (`req`/`addr_ok`/`data_ok`). It keeps up to `MAX_OUT` accepted requests in flight in an in-order pending queue. It also generates byte strobes and store-data replication, detects misalignment, performs load extraction and sign/zero extension, and discards responses belonging to flushed instructions.

## Interface
Parameters:
- `MAX_OUT`, 2: maximum accepted-but-unanswered requests (power of two, ≥1).
- `TAG_W`, 5: width of the destination tag carried with each request.

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- `cpu_clk_50M` in 1: the single clock.
- `cpu_rst_n` in 1: reset, asynchronous, active-low.
- `op_valid` in 1: the pipeline presents a memory op.
- `op_load` in 1: 1 = load, 0 = store.
- `op_size` in 2: `MEM_SIZE_B`=0, `MEM_SIZE_H`=1, `MEM_SIZE_W`=2.
- `op_unsigned` in 1: zero-extend the load result.
- `op_addr` in 32: byte address.
- `op_wdata` in 32: store data, right-aligned.
- `op_tag` in TAG_W: destination tag, returned with the response.
- `op_ready` out 1: the op is consumed this cycle.
- `op_misalign` out 1: the op is misaligned and is consumed without a bus request.
- `flush` in 1: kill the presented op and all in-flight ops.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2, `data_addr` out 32, `data_wstrb` out 4, `data_wdata` out 32: request channel.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata` in 32: bus handshake and read data.
- `rsp_valid` out 1, `rsp_load` out 1, `rsp_tag` out TAG_W, `rsp_data` out 32: registered response.
- `busy` out 1: the queue is non-empty.
- `stall` out 1: `op_valid & ~op_ready`.
- `proto_err` out 1: sticky; set when `data_data_ok` arrives with the queue empty.

## Operation
Misalignment:
- Condition: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- `op_misalign`=1, `op_ready`=1, `data_req`=0.

Request issue:
- `data_req = op_valid & ~op_misalign & ~flush & (count < MAX_OUT)`.
- Accept when `data_req & data_addr_ok`; then `op_ready`=1.
- On accept, push {load, size, unsigned, addr[1:0], tag, killed=0}.
- `data_addr` = `op_addr`; `data_size` = `op_size`; `data_wr` = ~`op_load`.

Byte-lane mapping: offset 0 maps to lane 3 (bits 31:24).
- Byte strobe: `4'b1000 >> off`.
- Half strobe: off 0 → 1100, off 2 → 0011.
- Word strobe: 1111.
- Loads drive `data_wstrb`=0.
- Store data: byte replicated ×4, half ×2, word unchanged.

Response path, on `data_data_ok`:
- Pop the queue head.
- If the head is not killed, next cycle: `rsp_valid`=1, `rsp_tag`=head tag, `rsp_load`=head load.
- Load data: extract the lane(s) selected by offset/size from `data_rdata` and sign- or zero-extend. Half at off 0 takes bits 31:16; half at off 2 takes bits 15:0.
- Stores: `rsp_data`=0.
- If the head is killed: pop silently, `rsp_valid`=0.

Flush:
- Sets `killed` on every queue entry.
- Forces `data_req`=0 that cycle.
- In-flight bus transactions are never cancelled; they drain normally.

## Timing
- Reset values: `count`=0, read/write pointers 0, all `killed`=0. Outputs `rsp_valid`=0, `rsp_load`=0, `rsp_tag`=0, `rsp_data`=0, `proto_err`=0.
- `data_req`, `op_ready`, `stall`, `op_misalign`, strobes and store data are combinational from the op inputs and `count`.
- Load-to-response latency: `rsp_*` is valid exactly 1 cycle after `data_data_ok`.
- Throughput: one accept per cycle while `count < MAX_OUT`.
- Push and pop in the same cycle: `count` is unchanged.
- Full queue: a same-cycle pop does not enable a push; `data_req` stays 0 until `count` has dropped.
- Pointers wrap modulo `MAX_OUT`.
- Flush in the same cycle as `data_data_ok`: the popped entry is suppressed, and entries that remain are marked killed.
- `data_data_ok` with an empty queue: ignored, `proto_err`←1.
- Asynchronous reset mid-transaction: all state clears immediately. Any late `data_data_ok` then sets `proto_err`.

## Structure
- Add `MEM_SIZE_B/H/W` and the entry-field widths to `defines.v`.
- Sub-module `mem_pend_fifo`: parametrised in-order queue with push/pop, count, and a broadcast kill-all.
- Lane extraction and strobe generation stay as functions inside `mem_access_unit`.

## Test plan
- Aligned word load, 0x100, `addr_ok` same cycle, `data_ok` 3 cycles later with rdata 0x11223344 → one `rsp_valid` pulse, `rsp_data`=0x11223344, correct tag.
- LB at offset 1, rdata 0x12F45678 → `rsp_data`=0xFFFFFFF4. LBU at the same address → 0x000000F4. LH at off 2 → 0x00005678.
- SB at offset 2 with wdata 0xAB → `data_wstrb`=0010, `data_wdata`=0xABABABAB. SH at off 0 → 1100.
- LH at 0x101 → `op_misalign`=1, `op_ready`=1, no `data_req`.
- MAX_OUT=2, three back-to-back loads with `data_ok` held off → third load gives `stall`=1 until the first `data_ok`; responses return in order.
- Two loads in flight, `flush` pulsed → both `data_ok`s produce no `rsp_valid`. `data_ok` with an empty queue → `proto_err`=1.
